// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver for 8N1 / 8E1 / 8O1 frames.
// Output is a one-entry valid/ready holding register.
module uart_rx_os #(
   parameter int unsigned OS_DIV     = 27,
   parameter bit          PARITY_EN  = 1'b1,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_in,
   input  logic       RX_ready,
   output logic [7:0] RX_out,
   output logic       RX_valid,
   output logic       parity_error,
   output logic       stop_error,
   output logic       overrun,
   output logic       RX_busy
);

   localparam logic [15:0] DIV_LAST = 16'(OS_DIV - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t      state_q, state_d;
   logic        sync1_q, sync2_q, sync3_q;
   logic [15:0] div_q, div_d;
   logic [3:0]  s_q, s_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        samp7_q, samp7_d, samp8_q, samp8_d;
   logic        par_q, par_d;
   logic [7:0]  out_q, out_d;
   logic        valid_q, valid_d;
   logic        perr_q, perr_d;
   logic        serr_q, serr_d;
   logic        ovr_q, ovr_d;

   logic fall, tick, maj, mid, last, done, handshake;

   assign fall      = sync3_q & ~sync2_q;
   assign tick      = (div_q == DIV_LAST);
   assign maj       = (samp7_q & samp8_q) | (samp7_q & sync2_q) | (samp8_q & sync2_q);
   assign mid       = tick && (s_q == 4'd9);
   assign last      = tick && (s_q == 4'd15);
   assign handshake = valid_q && RX_ready;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         sync3_q <= 1'b1;
         state_q <= IDLE;
         div_q   <= '0;
         s_q     <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         samp7_q <= 1'b1;
         samp8_q <= 1'b1;
         par_q   <= 1'b0;
         out_q   <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         serr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync1_q <= RX_in;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         state_q <= state_d;
         div_q   <= div_d;
         s_q     <= s_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         samp7_q <= samp7_d;
         samp8_q <= samp8_d;
         par_q   <= par_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         serr_q  <= serr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = tick ? '0 : div_q + 16'd1;
      s_d     = s_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      samp7_d = samp7_q;
      samp8_d = samp8_q;
      par_d   = par_q;
      done    = 1'b0;

      if (tick && state_q != IDLE) s_d = s_q + 4'd1;
      if (tick && s_q == 4'd7) samp7_d = sync2_q;
      if (tick && s_q == 4'd8) samp8_d = sync2_q;

      case (state_q)
         IDLE: begin
            // Divider restarts on the edge so ticks stay phase-locked to the frame.
            if (fall) begin
               state_d = START;
               div_d   = '0;
               s_d     = '0;
               bit_d   = '0;
            end
         end
         START: begin
            if (mid && maj)  state_d = IDLE;
            else if (last)   state_d = DATA;
         end
         DATA: begin
            if (mid) shreg_d = {maj, shreg_q[7:1]};
            if (last) begin
               if (bit_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         PARITY: begin
            if (mid)  par_d   = maj;
            if (last) state_d = STOP;
         end
         STOP: begin
            // Leave at the mid-bit decision so a back-to-back start edge is seen.
            if (mid) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_d   = out_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      serr_d  = serr_q;
      ovr_d   = ovr_q;
      if (handshake) begin
         valid_d = 1'b0;
         perr_d  = 1'b0;
         serr_d  = 1'b0;
         ovr_d   = 1'b0;
      end
      if (done) begin
         if (!valid_q || handshake) begin
            out_d   = shreg_q;
            perr_d  = PARITY_EN ? (^shreg_q ^ par_q ^ PARITY_ODD) : 1'b0;
            serr_d  = ~maj;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign RX_out       = out_q;
   assign RX_valid     = valid_q;
   assign parity_error = perr_q;
   assign stop_error   = serr_q;
   assign overrun      = ovr_q;
   assign RX_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an even-parity and an odd-parity receiver share one line.
module tb_uart_rx_os;

   localparam int BIT_CLKS = 64;
   // Start edge driven before posedge N -> RX_valid visible after posedge N+682.
   localparam int LAT      = 682;

   typedef struct {
      logic [7:0] data;
      logic       pe_e;
      logic       pe_o;
      logic       se;
      int         cyc;
   } item_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] out0, out1;
   logic       v0, v1, pe0, pe1, se0, se1, ov0, ov1, b0, b1;

   item_t sb[$];
   int    cyc = 0;
   int    total = 0;
   int    bad = 0;
   bit    seen = 1'b0;

   uart_rx_os #(.OS_DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
      .CLK(clk), .RST(rst_n), .RX_in(rx), .RX_ready(ready),
      .RX_out(out0), .RX_valid(v0), .parity_error(pe0), .stop_error(se0),
      .overrun(ov0), .RX_busy(b0));

   uart_rx_os #(.OS_DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
      .CLK(clk), .RST(rst_n), .RX_in(rx), .RX_ready(ready),
      .RX_out(out1), .RX_valid(v1), .parity_error(pe1), .stop_error(se1),
      .overrun(ov1), .RX_busy(b1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   // Monitor: one pop per frame presented by the even receiver.
   always @(negedge clk) begin
      item_t it;
      if (!v0) seen = 1'b0;
      else if (!seen) begin
         seen = 1'b1;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_valid: RX_valid high with no frame expected, cycle %0d", cyc);
         end else begin
            it = sb.pop_front();
            chk("latency",      cyc,  it.cyc);
            chk("data_even",    out0, it.data);
            chk("data_odd",     out1, it.data);
            chk("valid_odd",    v1,   1);
            chk("perr_even",    pe0,  it.pe_e);
            chk("perr_odd",     pe1,  it.pe_o);
            chk("serr_even",    se0,  it.se);
            chk("serr_odd",     se1,  it.se);
         end
      end
   end

   task automatic push_item(input logic [7:0] d, input logic pb, input logic stopb);
      item_t it;
      it.data = d;
      it.pe_e = ^d ^ pb;
      it.pe_o = ~(^d ^ pb);
      it.se   = ~stopb;
      it.cyc  = cyc + 1 + LAT;
      sb.push_back(it);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pb, input logic stopb,
                             input int nbits, input bit expect_it);
      logic [10:0] fr;
      fr = {stopb, pb, d, 1'b0};
      @(negedge clk);
      if (expect_it) push_item(d, pb, stopb);
      for (int i = 0; i < nbits; i++) begin
         rx = fr[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", sb.size(), 0);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_out"},   {out1, out0}, 0);
      chk({tag, "_valid"}, {v1, v0},     0);
      chk({tag, "_perr"},  {pe1, pe0},   0);
      chk({tag, "_serr"},  {se1, se0},   0);
      chk({tag, "_ovr"},   {ov1, ov0},   0);
      chk({tag, "_busy"},  {b1, b0},     0);
   endtask

   initial begin
      repeat (5) @(negedge clk);
      check_cleared("reset");
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // 0xA5 with correct even parity; 0x3C with wrong even / right odd parity.
      send_frame(8'hA5, 1'b0, 1'b1, 11, 1'b1);
      wait_drain(200);
      send_frame(8'h3C, 1'b1, 1'b1, 11, 1'b1);
      wait_drain(200);

      // Short low glitch must be rejected as a false start.
      @(negedge clk);
      rx = 1'b0;
      repeat (10) @(negedge clk);
      chk("glitch_busy_high", b0, 1);
      repeat (10) @(negedge clk);
      rx = 1'b1;
      repeat (44) @(negedge clk);
      chk("glitch_busy_low", b0, 0);
      chk("glitch_no_valid", v0, 0);
      send_frame(8'h55, 1'b0, 1'b1, 11, 1'b1);
      wait_drain(200);

      // Overrun: second frame discarded while the first is held.
      ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1, 11, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1, 11, 1'b0);
      repeat (4) @(negedge clk);
      chk("ovr_set_even", ov0, 1);
      chk("ovr_set_odd",  ov1, 1);
      chk("ovr_hold_out", out0, 8'h11);
      chk("ovr_hold_valid", v0, 1);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk("ovr_consumed_valid", v0, 0);
      chk("ovr_cleared", {ov1, ov0}, 0);
      ready = 1'b1;
      repeat (20) @(negedge clk);

      // Break: line low for 30 bit periods yields exactly one zero frame.
      @(negedge clk);
      push_item(8'h00, 1'b0, 1'b0);
      rx = 1'b0;
      repeat (30 * BIT_CLKS) @(negedge clk);
      rx = 1'b1;
      repeat (100) @(negedge clk);
      chk("break_single_frame", sb.size(), 0);
      send_frame(8'h7E, 1'b0, 1'b1, 11, 1'b1);
      wait_drain(200);

      // Reset in the middle of the data bits.
      send_frame(8'hF0, 1'b0, 1'b1, 4, 1'b0);
      chk("midframe_busy", b0, 1);
      rst_n = 1'b0;
      #1;
      check_cleared("midreset");
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      send_frame(8'h0F, 1'b0, 1'b1, 11, 1'b1);
      wait_drain(200);

      repeat (50) @(negedge clk);
      chk("final_idle", {b1, b0}, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Standalone 16x-oversampling UART receiver: the far end of the serial link driven by the existing UART transmitter.
- Takes an asynchronous external line, recovers 8N1 or 8E1/8O1 frames, and presents each byte through a one-entry valid/ready holding register.
- Generates its own oversample tick from the system clock, so it needs no external baud clock.

Parameters:
- OS_DIV, 27, system clocks per oversample tick (16 ticks per bit; 27 gives about 115200 baud at 50 MHz); legal range 2..65535.
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
- CLK  input  1  system clock; all state on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- RX_in  input  1  serial line; idles high; asynchronous to CLK.
- RX_ready  input  1  consumer accepts the held byte when RX_ready and RX_valid are both high.
- RX_out  output  8  received byte, LSB first on the line.
- RX_valid  output  1  RX_out holds an unconsumed byte.
- parity_error  output  1  parity mismatch on the held frame.
- stop_error  output  1  stop bit sampled low on the held frame.
- overrun  output  1  sticky; a frame completed while RX_valid was high.
- RX_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (RST low, asynchronous):
  - Synchroniser flops reset to 1.
  - State goes to IDLE; tick divider, tick counter and bit counter clear.
  - All outputs go to 0, RX_out to 8'h00.
- Synchroniser and edge detect: RX_in passes through two flops; a start is the synchronised value changing 1 -> 0.
- Tick divider:
  - Counts 0..OS_DIV-1 and emits a one-clock tick at terminal count.
  - Free-running, but forced to 0 on start detection so bit phase aligns to the detected edge.
- Per-bit sampling: tick counter s counts 0..15. The bit value is the majority of the synchronised line at the ticks where s = 7, 8, 9. The bit decision is taken at s = 9; the state advances at s = 15.
- State machine: IDLE -> START -> DATA -> PARITY (only when PARITY_EN = 1) -> STOP -> IDLE.
  - IDLE: on a falling edge, go to START with s = 0.
  - START: if the majority at s = 9 is 1, this is a false start; return to IDLE immediately and change no outputs. Otherwise continue.
  - DATA: shift 8 bits, LSB first; the bit counter ends at 7.
  - PARITY: compute p = XOR of the 8 data bits XOR the received parity bit XOR PARITY_ODD. A frame error exists when p = 1.
  - STOP: at the s = 9 decision, complete the frame and return to IDLE. The STOP state does not wait for s = 15, so a back-to-back start edge is caught.
- Frame completion (clock after the STOP decision):
  - If RX_valid = 0: load RX_out, parity_error and stop_error from this frame, and set RX_valid = 1.
  - If RX_valid = 1: discard the new frame, set overrun = 1, and leave RX_out and both error flags unchanged.
  - A completion on the same cycle as a handshake counts as RX_valid = 0: the new frame loads and overrun is not set.
- Handshake:
  - RX_valid && RX_ready in a cycle with no simultaneous completion: RX_valid, parity_error and stop_error clear the next clock.
  - overrun clears only on a handshake.
  - RX_out keeps its last value after consumption.
- Stop error: the frame is still delivered, with stop_error = 1. A following start needs a fresh 1 -> 0 edge, so a held-low break line produces exactly one frame with RX_out = 8'h00 and stop_error = 1.
- Latency: RX_valid rises exactly 1 clock after the stop-bit s = 9 tick.
- RX_busy is high from the start-detect clock until the return to IDLE.
- Reset mid-frame: the partial frame is lost and the next falling edge starts cleanly.

Test Plan:
- OS_DIV=4 (64 clk/bit), PARITY_EN=1 even; send 0xA5, parity 0, stop 1 -> RX_valid rises 1 clk after stop mid-sample; RX_out=0xA5; parity_error=0; stop_error=0.
- Same config; send 0x3C with parity bit 1 -> RX_out=0x3C, parity_error=1; set PARITY_ODD=1 and resend the same bit pattern -> parity_error=0.
- Low glitch of 20 clks on an idle line -> no RX_valid, RX_busy returns to 0 within one bit period; then send 0x55 -> RX_out=0x55.
- Hold RX_ready=0, send 0x11 then 0x22 back-to-back -> RX_out=0x11, overrun=1; pulse RX_ready for 1 clk -> RX_valid=0, overrun=0.
- Line held low for 30 bit periods, then released -> exactly one frame: RX_out=0x00, stop_error=1; send 0x7E -> RX_out=0x7E, stop_error=0.
- Assert RST low mid-DATA while sending 0xF0 -> all outputs 0 immediately; after release, send 0x0F -> RX_out=0x0F with no errors.
